mult_wb_arbiter: RTL and testbench
==================================

// Module: mult_wb_arbiter
// PURPOSE
//  Consumer end of the multiplier stage-latch chain (mult1..mult5). Merges final mult results
//  with the main pipeline writeback onto the single register-file write port. Main pipeline
//  has priority; colliding mult results queue in a FIFO. A stall is raised to decode before
//  in-flight mults could overflow the queue. Mult latches never stall.
// PARAMETERS
//  DEPTH     8  mult result FIFO entries (power of 2, DEPTH > INFLIGHT)
//  INFLIGHT  5  mult stage latches between issue and this block
// PORTS
//  clk_i                    in   1   clock
//  rst_i                    in   1   reset, synchronous, active-high
//  mult_int_write_data_i    in   32  final mult stage result
//  mult_write_addr_i        in   5   destination register
//  mult_int_write_enable_i  in   1   mult entry valid
//  mult_instruction_i       in   32  instruction word
//  mult_pc_i                in   32  instruction PC
//  main_int_write_data_i    in   32  main pipeline writeback data
//  main_write_addr_i        in   5   main pipeline destination
//  main_int_write_enable_i  in   1   main pipeline write valid
//  main_instruction_i       in   32  instruction word
//  main_pc_i                in   32  instruction PC
//  rf_write_data_o          out  32  register-file write data (registered)
//  rf_write_addr_o          out  5   register-file write address (registered)
//  rf_write_enable_o        out  1   register-file write enable (registered)
//  rf_instruction_o         out  32  retiring instruction (registered)
//  rf_pc_o                  out  32  retiring PC (registered)
//  rf_src_mult_o            out  1   1 = write came from mult path (registered)
//  mult_issue_stall_o       out  1   block new mult issue in decode
//  overflow_o               out  1   sticky: mult entry dropped on full FIFO
// BEHAVIOUR
//  - Reset: all rf_* outputs 0, FIFO empty (count 0), overflow_o 0, mult_issue_stall_o 0.
//    Reset mid-operation flushes queued entries; they are lost.
//  - Mult entry counts only if mult_int_write_enable_i=1 and mult_write_addr_i!=0; others ignored.
//  - Per cycle, priority, result registered to rf_* on the next edge (latency 1):
//    1. main_int_write_enable_i=1: rf <- main, src=0; a valid mult entry is pushed.
//    2. else FIFO non-empty: rf <- FIFO head, src=1, pop; a valid mult entry is pushed
//       (simultaneous push/pop, count unchanged).
//    3. else valid mult entry: rf <- mult inputs directly (bypass, no push), src=1.
//    4. else rf_write_enable_o <= 0; other rf_* hold previous values.
//  - Ordering: mult results retire in arrival order; bypass only when FIFO empty.
//  - Full: push with count==DEPTH and no pop drops the entry, sets overflow_o (sticky to reset).
//    Push with pop on full is legal.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - mult_issue_stall_o = (count >= DEPTH-INFLIGHT), combinational from the count register.
// CONFIGURATION
//  MULT_WB_FWD_EN defined: adds ports hz_addr_i (in, 5) and hz_pending_o (out, 1).
//   hz_pending_o = 1 (combinational) when hz_addr_i!=0 and it matches any valid FIFO entry
//   or the current valid mult input; decode uses it to hold dependent instructions.
//  Not defined: ports absent, no comparator logic; decode relies on its own scoreboard.
// TESTING
//  - Reset held 2 cycles with inputs active -> all rf_* 0, stall 0, overflow 0.
//  - Lone mult x5=0x0000_0030 -> next cycle rf_we=1, addr=5, data=0x30, src_mult=1.
//  - Main x3=0x11 and mult x7=0x22 same cycle -> cycle+1 writes x3 (src 0),
//    cycle+2 writes x7 (src 1).
//  - 3 back-to-back collisions -> count 3, stall=1; main idle -> queue drains in order,
//    stall drops when count<3.
//  - Force 9 queued pushes with main busy -> 9th dropped, overflow_o=1 until reset.
//  - FWD_EN: x9 queued, hz_addr_i=9 -> hz_pending_o=1; hz_addr_i=0 -> 0.

Source files
------------

// File: rtl/mult_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mult_wb_arbiter
//
// Purpose:
//   Merges the final multiplier stage-latch results with the main pipeline
//   writeback onto the single register-file write port. The main pipeline
//   always wins. A mult result that collides with a main write waits in a FIFO.
//   Queued mult results retire in arrival order. A mult result bypasses the
//   FIFO only when the FIFO is empty. Decode is told to stop issuing mults
//   while the FIFO could otherwise overflow from the results still in flight.
//   If an entry is dropped on a full FIFO anyway, a sticky flag is raised.
//
// Parameters:
//   DEPTH     mult result FIFO entries (power of 2, DEPTH > INFLIGHT)
//   INFLIGHT  mult stage latches between issue and this block
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   mult_int_write_data_i/addr/...   final mult stage result, dest, valid,
//                                    instruction word and PC
//   main_int_write_data_i/addr/...   main pipeline writeback, dest, valid,
//                                    instruction word and PC
//   rf_write_data_o/addr/enable      registered register-file write port
//   rf_instruction_o, rf_pc_o        registered retiring instruction and PC
//   rf_src_mult_o                    registered: 1 = write came from mult path
//   mult_issue_stall_o               blocks new mult issue in decode
//   overflow_o                       sticky: a mult entry was dropped
//
// Optional feature (macro MULT_WB_FWD_EN):
//   Adds hz_addr_i / hz_pending_o. hz_pending_o is high when hz_addr_i is
//   non-zero and matches a valid FIFO entry or the current valid mult input.
// -----------------------------------------------------------------------------
module mult_wb_arbiter #(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mult_int_write_data_i,
    input  logic [4:0]  mult_write_addr_i,
    input  logic        mult_int_write_enable_i,
    input  logic [31:0] mult_instruction_i,
    input  logic [31:0] mult_pc_i,
    input  logic [31:0] main_int_write_data_i,
    input  logic [4:0]  main_write_addr_i,
    input  logic        main_int_write_enable_i,
    input  logic [31:0] main_instruction_i,
    input  logic [31:0] main_pc_i,
    output logic [31:0] rf_write_data_o,
    output logic [4:0]  rf_write_addr_o,
    output logic        rf_write_enable_o,
    output logic [31:0] rf_instruction_o,
    output logic [31:0] rf_pc_o,
    output logic        rf_src_mult_o,
`ifdef MULT_WB_FWD_EN
    input  logic [4:0]  hz_addr_i,
    output logic        hz_pending_o,
`endif
    output logic        mult_issue_stall_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // FIFO storage (data only, never reset)
    logic [31:0] fifo_data_q  [DEPTH];
    logic [4:0]  fifo_addr_q  [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];

    // Control state
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Registered write port
    logic [31:0] rf_data_q,  rf_data_d;
    logic [4:0]  rf_addr_q,  rf_addr_d;
    logic        rf_we_q,    rf_we_d;
    logic [31:0] rf_instr_q, rf_instr_d;
    logic [31:0] rf_pc_q,    rf_pc_d;
    logic        rf_src_q,   rf_src_d;

    logic mult_vld;
    logic push, pop, push_ok, fifo_full;

    // A write to x0 is architecturally a no-op, so it never occupies a slot.
    assign mult_vld  = mult_int_write_enable_i && (mult_write_addr_i != 5'd0);
    assign fifo_full = (count_q == CW'(DEPTH));

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        rf_we_d    = 1'b0;
        rf_data_d  = rf_data_q;
        rf_addr_d  = rf_addr_q;
        rf_instr_d = rf_instr_q;
        rf_pc_d    = rf_pc_q;
        rf_src_d   = rf_src_q;

        if (main_int_write_enable_i) begin
            rf_we_d    = 1'b1;
            rf_data_d  = main_int_write_data_i;
            rf_addr_d  = main_write_addr_i;
            rf_instr_d = main_instruction_i;
            rf_pc_d    = main_pc_i;
            rf_src_d   = 1'b0;
            push       = mult_vld;
        end else if (count_q != '0) begin
            rf_we_d    = 1'b1;
            rf_data_d  = fifo_data_q[rd_ptr_q];
            rf_addr_d  = fifo_addr_q[rd_ptr_q];
            rf_instr_d = fifo_instr_q[rd_ptr_q];
            rf_pc_d    = fifo_pc_q[rd_ptr_q];
            rf_src_d   = 1'b1;
            pop        = 1'b1;
            push       = mult_vld;
        end else if (mult_vld) begin
            // The FIFO is empty, so bypassing cannot reorder mult results.
            rf_we_d    = 1'b1;
            rf_data_d  = mult_int_write_data_i;
            rf_addr_d  = mult_write_addr_i;
            rf_instr_d = mult_instruction_i;
            rf_pc_d    = mult_pc_i;
            rf_src_d   = 1'b1;
        end

        // A pop in the same cycle frees a slot, so a push on full is legal then.
        push_ok    = push && (!fifo_full || pop);
        overflow_d = overflow_q || (push && fifo_full && !pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_data_q  <= '0;
            rf_addr_q  <= '0;
            rf_instr_q <= '0;
            rf_pc_q    <= '0;
            rf_src_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rf_we_q    <= rf_we_d;
            rf_data_q  <= rf_data_d;
            rf_addr_q  <= rf_addr_d;
            rf_instr_q <= rf_instr_d;
            rf_pc_q    <= rf_pc_d;
            rf_src_q   <= rf_src_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_data_q[wr_ptr_q]  <= mult_int_write_data_i;
            fifo_addr_q[wr_ptr_q]  <= mult_write_addr_i;
            fifo_instr_q[wr_ptr_q] <= mult_instruction_i;
            fifo_pc_q[wr_ptr_q]    <= mult_pc_i;
        end
    end

`ifdef MULT_WB_FWD_EN
    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    logic hz_hit;
    always_comb begin
        hz_hit = mult_vld && (mult_write_addr_i == hz_addr_i);
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(AW'(AW'(i) - rd_ptr_q)) < count_q) && (fifo_addr_q[i] == hz_addr_i)) begin
                hz_hit = 1'b1;
            end
        end
    end
    assign hz_pending_o = hz_hit && (hz_addr_i != 5'd0);
`endif

    assign rf_write_data_o    = rf_data_q;
    assign rf_write_addr_o    = rf_addr_q;
    assign rf_write_enable_o  = rf_we_q;
    assign rf_instruction_o   = rf_instr_q;
    assign rf_pc_o            = rf_pc_q;
    assign rf_src_mult_o      = rf_src_q;
    assign mult_issue_stall_o = (count_q >= CW'(DEPTH - INFLIGHT));
    assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
module tb_mult_wb_arbiter;

    typedef struct packed {
        logic        src;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mult_data, mult_instr, mult_pc;
    logic [4:0]  mult_addr;
    logic        mult_we;
    logic [31:0] main_data, main_instr, main_pc;
    logic [4:0]  main_addr;
    logic        main_we;
    logic [31:0] rf_data, rf_instr, rf_pc;
    logic [4:0]  rf_addr;
    logic        rf_we, rf_src, stall, overflow;
`ifdef MULT_WB_FWD_EN
    logic [4:0]  hz_addr;
    logic        hz_pending;
`endif

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp_q[$];
    wr_t mon_exp;
    wr_t mon_act;

    mult_wb_arbiter #(.DEPTH(8), .INFLIGHT(5)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .mult_int_write_data_i   (mult_data),
        .mult_write_addr_i       (mult_addr),
        .mult_int_write_enable_i (mult_we),
        .mult_instruction_i      (mult_instr),
        .mult_pc_i               (mult_pc),
        .main_int_write_data_i   (main_data),
        .main_write_addr_i       (main_addr),
        .main_int_write_enable_i (main_we),
        .main_instruction_i      (main_instr),
        .main_pc_i               (main_pc),
        .rf_write_data_o         (rf_data),
        .rf_write_addr_o         (rf_addr),
        .rf_write_enable_o       (rf_we),
        .rf_instruction_o        (rf_instr),
        .rf_pc_o                 (rf_pc),
        .rf_src_mult_o           (rf_src),
`ifdef MULT_WB_FWD_EN
        .hz_addr_i               (hz_addr),
        .hz_pending_o            (hz_pending),
`endif
        .mult_issue_stall_o      (stall),
        .overflow_o              (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic src, input logic [31:0] d);
        return src ? (32'h3000_0000 | d) : (32'h1000_0000 | d);
    endfunction

    function automatic logic [31:0] pc_of(input logic src, input logic [31:0] d);
        return src ? (32'h4000_0000 | d) : (32'h2000_0000 | d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic uv, input logic [4:0] ua, input logic [31:0] ud);
        main_we    = mv;
        main_addr  = ma;
        main_data  = md;
        main_instr = instr_of(1'b0, md);
        main_pc    = pc_of(1'b0, md);
        mult_we    = uv;
        mult_addr  = ua;
        mult_data  = ud;
        mult_instr = instr_of(1'b1, ud);
        mult_pc    = pc_of(1'b1, ud);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic src, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.src   = src;
        e.addr  = a;
        e.data  = d;
        e.instr = instr_of(src, d);
        e.pc    = pc_of(src, d);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every register-file write must match the next
    // expected write, in order.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            mon_act = '{rf_src, rf_addr, rf_data, rf_instr, rf_pc};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got src=%0d addr=%0d data=0x%08h, expected no write",
                         rf_src, rf_addr, rf_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_errors++;
                    $display("FAIL rf_write: got src=%0d addr=%0d data=0x%08h instr=0x%08h pc=0x%08h, expected src=%0d addr=%0d data=0x%08h instr=0x%08h pc=0x%08h",
                             mon_act.src, mon_act.addr, mon_act.data, mon_act.instr, mon_act.pc,
                             mon_exp.src, mon_exp.addr, mon_exp.data, mon_exp.instr, mon_exp.pc);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with both inputs active
        rst = 1'b1;
`ifdef MULT_WB_FWD_EN
        hz_addr = 5'd0;
`endif
        drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
        tick();
        tick();
        check("reset_we", rf_we, 0);
        check("reset_data", rf_data, 0);
        check("reset_addr", rf_addr, 0);
        check("reset_instr", rf_instr, 0);
        check("reset_pc", rf_pc, 0);
        check("reset_src", rf_src, 0);
        check("reset_stall", stall, 0);
        check("reset_overflow", overflow, 0);
        idle();
        rst = 1'b0;
        tick();

        // Lone mult x5 = 0x30 bypasses with one cycle of latency
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h30);
        expect_wr(1'b1, 5'd5, 32'h30);
        tick();
        check("bypass_latency_we", rf_we, 1);
        check("bypass_src", rf_src, 1);
        idle();
        tick();
        check("idle_we_low", rf_we, 0);
        check("idle_addr_hold", rf_addr, 5);
        check("idle_data_hold", rf_data, 32'h30);

        // A mult write to x0 is ignored
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
        tick();
        check("x0_ignored", rf_we, 0);
        check("x0_no_stall", stall, 0);
        idle();
        tick();

        // Collision: main x3 retires first, then mult x7
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        expect_wr(1'b0, 5'd3, 32'h11);
        expect_wr(1'b1, 5'd7, 32'h22);
        tick();
        check("collide_main_addr", rf_addr, 3);
        idle();
        tick();
        check("collide_mult_addr", rf_addr, 7);
        check("collide_mult_src", rf_src, 1);
        tick();

        // Three back-to-back collisions: stall at count 3, drain in order
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(1 + i), 32'h100 + i, 1'b1, 5'(10 + i), 32'h200 + i);
            expect_wr(1'b0, 5'(1 + i), 32'h100 + i);
            tick();
            if (i == 1) check("stall_at_2", stall, 0);
            if (i == 2) check("stall_at_3", stall, 1);
        end
        for (int i = 0; i < 3; i++) expect_wr(1'b1, 5'(10 + i), 32'h200 + i);
        idle();
        tick();
        check("stall_drop_at_2", stall, 0);
        wait_drain("drain_3");

        // Nine queued pushes with main busy: ninth dropped, overflow sticky
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 5'd1, 32'h300 + i, 1'b1, 5'(8 + i), 32'h400 + i);
            expect_wr(1'b0, 5'd1, 32'h300 + i);
            tick();
            if (i == 8) check("full_no_overflow", overflow, 0);
            if (i == 8) check("full_stall", stall, 1);
            if (i == 9) check("overflow_set", overflow, 1);
        end
        for (int i = 1; i <= 8; i++) expect_wr(1'b1, 5'(8 + i), 32'h400 + i);
`ifdef MULT_WB_FWD_EN
        hz_addr = 5'd9;
        #1 check("hz_queued_x9", hz_pending, 1);
        hz_addr = 5'd17;
        #1 check("hz_mult_input_x17", hz_pending, 1);
        hz_addr = 5'd0;
        #1 check("hz_x0", hz_pending, 0);
        idle();
        hz_addr = 5'd17;
        #1 check("hz_dropped_x17", hz_pending, 0);
        hz_addr = 5'd0;
`endif

        // Push with pop on a full FIFO is legal and keeps order
        expect_wr(1'b1, 5'd20, 32'h500);
        expect_wr(1'b1, 5'd21, 32'h501);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h500);
        tick();
        check("full_pushpop_stall", stall, 1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h501);
        tick();
        idle();
        wait_drain("drain_full");
        check("overflow_sticky", overflow, 1);

        // Reset clears overflow
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("overflow_cleared", overflow, 0);

        // Reset mid-operation flushes queued entries
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'(1 + i), 32'h600 + i, 1'b1, 5'(24 + i), 32'h700 + i);
            expect_wr(1'b0, 5'(1 + i), 32'h600 + i);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("flush_stall", stall, 0);
        check("flush_we", rf_we, 0);
        wait_drain("drain_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
